// File: rtl/alu_pkg.sv
// Shared types for the multi-lane ALU: command, response and lane state
// encodings used by the lanes, the bank wrapper and its interface.
package alu_pkg;

   typedef enum logic [1:0] {
      CMD_ADD = 2'd0,
      CMD_SUB = 2'd1,
      CMD_SHL = 2'd2,
      CMD_SHR = 2'd3
   } command_names_t;

   typedef enum logic [1:0] {
      RESP_NONE      = 2'd0,
      RESP_OK        = 2'd1,
      RESP_OVERFLOW  = 2'd2,
      RESP_UNDERFLOW = 2'd3
   } response_names_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } lane_state_t;

endpackage

// File: rtl/alu_bank_array_if.sv
// Per-lane command/result handshake bundle between issuers, the ALU bank
// and result consumers; every field is an array indexed by lane.
interface alu_bank_array_if #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int CNT_W    = 16
);
   import alu_pkg::*;

   logic [CHANNELS-1:0]                in_valid;
   logic [CHANNELS-1:0]                in_ready;
   command_names_t [CHANNELS-1:0]      in_command;
   logic [CHANNELS-1:0][WIDTH-1:0]     in_data1;
   logic [CHANNELS-1:0][WIDTH-1:0]     in_data2;
   logic [CHANNELS-1:0]                out_valid;
   logic [CHANNELS-1:0]                out_ready;
   logic [CHANNELS-1:0][WIDTH-1:0]     out_data;
   response_names_t [CHANNELS-1:0]     out_response;
   logic [CHANNELS-1:0][CNT_W-1:0]     done_count;

   modport master (
      output in_valid,
      output in_command,
      output in_data1,
      output in_data2,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_response,
      input  done_count
   );

   modport slave (
      input  in_valid,
      input  in_command,
      input  in_data1,
      input  in_data2,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_response,
      output done_count
   );

endinterface

// File: rtl/alu_lane.sv
// One ALU lane: add/sub in a single cycle, shifts one bit per cycle,
// result held in DONE until taken, plus a wrapping completion counter.
module alu_lane
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  command_names_t     in_command,
   input  logic [WIDTH-1:0]   in_data1,
   input  logic [WIDTH-1:0]   in_data2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output response_names_t    out_response,
   output logic [CNT_W-1:0]   done_count
);

   localparam int SW = $clog2(WIDTH);

   lane_state_t       state_q, state_d;
   logic [WIDTH-1:0]  work_q, work_d;
   logic [SW-1:0]     amt_q, amt_d;
   logic              left_q, left_d;
   logic              spill_q, spill_d;
   logic [WIDTH-1:0]  res_q, res_d;
   response_names_t   resp_q, resp_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [WIDTH:0]    sum;
   logic [WIDTH-1:0]  step;
   logic              spill_nxt;

   assign out_data     = res_q;
   assign out_response = resp_q;
   assign done_count   = cnt_q;

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      amt_d     = amt_q;
      left_d    = left_q;
      spill_d   = spill_q;
      res_d     = res_q;
      resp_d    = resp_q;
      cnt_d     = cnt_q;
      sum       = {1'b0, in_data1} + {1'b0, in_data2};
      step      = left_q ? (work_q << 1) : (work_q >> 1);
      spill_nxt = spill_q | (left_q & work_q[WIDTH-1]);
      in_ready  = (state_q == IDLE) ||
                  ((state_q == DONE) && out_ready);
      out_valid = (state_q == DONE);

      unique case (state_q)
         IDLE: ;
         SHIFT: begin
            work_d  = step;
            amt_d   = amt_q - SW'(1);
            spill_d = spill_nxt;
            if (amt_q == SW'(1)) begin
               res_d   = step;
               resp_d  = spill_nxt ? RESP_OVERFLOW : RESP_OK;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = IDLE;
            end
         end
      endcase

      // A new command may land in the same cycle the old result is taken.
      if (in_ready && in_valid) begin
         unique case (in_command)
            CMD_ADD: begin
               res_d   = sum[WIDTH-1:0];
               resp_d  = sum[WIDTH] ? RESP_OVERFLOW : RESP_OK;
               state_d = DONE;
            end
            CMD_SUB: begin
               res_d   = in_data1 - in_data2;
               resp_d  = (in_data1 < in_data2) ? RESP_UNDERFLOW
                                               : RESP_OK;
               state_d = DONE;
            end
            CMD_SHL, CMD_SHR: begin
               if (in_data2[SW-1:0] == '0) begin
                  res_d   = in_data1;
                  resp_d  = RESP_OK;
                  state_d = DONE;
               end else begin
                  work_d  = in_data1;
                  amt_d   = in_data2[SW-1:0];
                  left_d  = (in_command == CMD_SHL);
                  spill_d = 1'b0;
                  state_d = SHIFT;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         work_q  <= '0;
         amt_q   <= '0;
         left_q  <= 1'b0;
         spill_q <= 1'b0;
         res_q   <= '0;
         resp_q  <= RESP_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         amt_q   <= amt_d;
         left_q  <= left_d;
         spill_q <= spill_d;
         res_q   <= res_d;
         resp_q  <= resp_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_bank_array.sv
// Bank of CHANNELS fully independent ALU lanes sharing one clock/reset;
// lane i is wired to element i of every interface array.
module alu_bank_array
   import alu_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int CNT_W    = 16
) (
   input  logic            clock,
   input  logic            reset,
   alu_bank_array_if.slave bus
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      alu_lane #(
         .WIDTH (WIDTH),
         .CNT_W (CNT_W)
      ) u_lane (
         .clock        (clock),
         .reset        (reset),
         .in_valid     (bus.in_valid[i]),
         .in_ready     (bus.in_ready[i]),
         .in_command   (bus.in_command[i]),
         .in_data1     (bus.in_data1[i]),
         .in_data2     (bus.in_data2[i]),
         .out_valid    (bus.out_valid[i]),
         .out_ready    (bus.out_ready[i]),
         .out_data     (bus.out_data[i]),
         .out_response (bus.out_response[i]),
         .done_count   (bus.done_count[i])
      );
   end

endmodule

// File: tb/tb_alu_bank_array.sv
// Bench for alu_bank_array: directed vector table, random ops against a
// plain-arithmetic model, backpressure, mid-op reset and counter wrap.
module tb_alu_bank_array;
   import alu_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   alu_bank_array_if #(.CHANNELS(4), .WIDTH(32), .CNT_W(16)) bus ();
   alu_bank_array #(.CHANNELS(4), .WIDTH(32), .CNT_W(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   alu_bank_array_if #(.CHANNELS(1), .WIDTH(8), .CNT_W(4)) busw ();
   alu_bank_array #(.CHANNELS(1), .WIDTH(8), .CNT_W(4)) dut_w (
      .clock (clock),
      .reset (reset),
      .bus   (busw)
   );

   typedef struct {
      int              ln;
      command_names_t  cmd;
      logic [31:0]     a;
      logic [31:0]     b;
      logic [31:0]     d;
      response_names_t r;
      int              lat;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int exp_cnt [4];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic void model(input command_names_t c,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] d,
                                 output response_names_t r,
                                 output int lat);
      logic [32:0] s;
      logic [63:0] w;
      int n;
      n = int'(b[4:0]);
      r = RESP_OK;
      lat = 1;
      d = '0;
      case (c)
         CMD_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            d = s[31:0];
            if (s[32]) r = RESP_OVERFLOW;
         end
         CMD_SUB: begin
            d = a - b;
            if (a < b) r = RESP_UNDERFLOW;
         end
         CMD_SHL: begin
            w = {32'd0, a} << n;
            d = w[31:0];
            if (w[63:32] != 0) r = RESP_OVERFLOW;
            lat = 1 + n;
         end
         default: begin
            d = a >> n;
            lat = 1 + n;
         end
      endcase
   endfunction

   // Issue one op on an idle lane, wait for its result, then take it.
   task automatic run_op(input int ln, input command_names_t c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input response_names_t er,
                         input int elat);
      int cyc;
      chk("op_in_ready", 64'(bus.in_ready[ln]), 64'd1);
      bus.in_command[ln] = c;
      bus.in_data1[ln] = a;
      bus.in_data2[ln] = b;
      bus.in_valid[ln] = 1'b1;
      tick();
      bus.in_valid[ln] = 1'b0;
      cyc = 1;
      while (!bus.out_valid[ln] && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("op_latency", 64'(cyc), 64'(elat));
      chk("op_data", 64'(bus.out_data[ln]), 64'(ed));
      chk("op_resp", 64'(bus.out_response[ln]), 64'(er));
      bus.out_ready[ln] = 1'b1;
      tick();
      bus.out_ready[ln] = 1'b0;
      exp_cnt[ln] = (exp_cnt[ln] + 1) & 16'hFFFF;
      chk("op_count", 64'(bus.done_count[ln]), 64'(exp_cnt[ln]));
      chk("op_valid_drop", 64'(bus.out_valid[ln]), 64'd0);
   endtask

   initial begin
      vec_t vecs [12];
      logic [31:0] ma [4];
      logic [31:0] mb [4];
      logic [31:0] md [4];
      response_names_t mr [4];
      int ml [4];
      int seen [4];
      logic [31:0] gd [4];
      response_names_t gr [4];
      command_names_t mc [4];

      vecs[0]  = '{0, CMD_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, RESP_OVERFLOW, 1};
      vecs[1]  = '{0, CMD_ADD, 32'd2, 32'd3, 32'd5, RESP_OK, 1};
      vecs[2]  = '{1, CMD_SUB, 32'd5, 32'd7, 32'hFFFFFFFE, RESP_UNDERFLOW, 1};
      vecs[3]  = '{1, CMD_SUB, 32'd7, 32'd5, 32'd2, RESP_OK, 1};
      vecs[4]  = '{2, CMD_SHL, 32'h1, 32'd4, 32'h10, RESP_OK, 5};
      vecs[5]  = '{2, CMD_SHL, 32'h80000000, 32'd1, 32'h0, RESP_OVERFLOW, 2};
      vecs[6]  = '{2, CMD_SHR, 32'hF0, 32'd0, 32'hF0, RESP_OK, 1};
      vecs[7]  = '{3, CMD_SHR, 32'h80000000, 32'd31, 32'h1, RESP_OK, 32};
      vecs[8]  = '{0, CMD_SHL, 32'h3, 32'd31, 32'h80000000, RESP_OVERFLOW, 32};
      vecs[9]  = '{1, CMD_SHL, 32'h1, 32'h25, 32'h20, RESP_OK, 6};
      vecs[10] = '{3, CMD_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, RESP_OK, 1};
      vecs[11] = '{3, CMD_SUB, 32'h0, 32'h0, 32'h0, RESP_OK, 1};

      bus.in_valid = '0;
      bus.out_ready = '0;
      bus.in_data1 = '0;
      bus.in_data2 = '0;
      for (int l = 0; l < 4; l++) begin
         bus.in_command[l] = CMD_ADD;
         exp_cnt[l] = 0;
      end
      busw.in_valid = '0;
      busw.out_ready = '0;
      busw.in_data1 = '0;
      busw.in_data2 = '0;
      busw.in_command[0] = CMD_ADD;

      repeat (3) tick();
      reset = 1'b0;
      #1;
      for (int l = 0; l < 4; l++) begin
         chk("rst_out_valid", 64'(bus.out_valid[l]), 64'd0);
         chk("rst_out_data", 64'(bus.out_data[l]), 64'd0);
         chk("rst_resp", 64'(bus.out_response[l]), 64'(RESP_NONE));
         chk("rst_count", 64'(bus.done_count[l]), 64'd0);
         chk("rst_in_ready", 64'(bus.in_ready[l]), 64'd1);
      end
      chk("rst_w_count", 64'(busw.done_count[0]), 64'd0);
      chk("rst_w_in_ready", 64'(busw.in_ready[0]), 64'd1);
      tick();

      // Lane 3 backpressure with same-cycle take-and-accept.
      bus.in_command[3] = CMD_ADD;
      bus.in_data1[3] = 32'd10;
      bus.in_data2[3] = 32'd20;
      bus.in_valid[3] = 1'b1;
      tick();
      bus.in_valid[3] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk("bp_valid", 64'(bus.out_valid[3]), 64'd1);
         chk("bp_data", 64'(bus.out_data[3]), 64'd30);
         chk("bp_resp", 64'(bus.out_response[3]), 64'(RESP_OK));
         chk("bp_in_ready", 64'(bus.in_ready[3]), 64'd0);
         tick();
      end
      bus.out_ready[3] = 1'b1;
      bus.in_command[3] = CMD_SUB;
      bus.in_data1[3] = 32'd9;
      bus.in_data2[3] = 32'd4;
      bus.in_valid[3] = 1'b1;
      #1;
      chk("bp_comb_ready", 64'(bus.in_ready[3]), 64'd1);
      tick();
      bus.in_valid[3] = 1'b0;
      bus.out_ready[3] = 1'b0;
      chk("bp_count", 64'(bus.done_count[3]), 64'd1);
      chk("bp_new_valid", 64'(bus.out_valid[3]), 64'd1);
      chk("bp_new_data", 64'(bus.out_data[3]), 64'd5);
      bus.out_ready[3] = 1'b1;
      tick();
      bus.out_ready[3] = 1'b0;
      exp_cnt[3] = 2;
      chk("bp_count2", 64'(bus.done_count[3]), 64'd2);

      for (int i = 0; i < 12; i++)
         run_op(vecs[i].ln, vecs[i].cmd, vecs[i].a, vecs[i].b,
                vecs[i].d, vecs[i].r, vecs[i].lat);

      for (int i = 0; i < 30; i++) begin
         int ln;
         command_names_t c;
         logic [31:0] a, b, d;
         response_names_t r;
         int lat;
         ln = int'($urandom_range(0, 3));
         c = command_names_t'($urandom_range(0, 3));
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 5)
                                         : $urandom;
         b = $urandom;
         model(c, a, b, d, r, lat);
         run_op(ln, c, a, b, d, r, lat);
      end

      // All lanes busy at once; results held until every lane is done.
      for (int round = 0; round < 4; round++) begin
         for (int l = 0; l < 4; l++) begin
            mc[l] = command_names_t'($urandom_range(0, 3));
            ma[l] = $urandom;
            mb[l] = $urandom;
            model(mc[l], ma[l], mb[l], md[l], mr[l], ml[l]);
            seen[l] = 0;
            bus.in_command[l] = mc[l];
            bus.in_data1[l] = ma[l];
            bus.in_data2[l] = mb[l];
         end
         bus.in_valid = 4'hF;
         tick();
         bus.in_valid = '0;
         for (int cyc = 1; cyc <= 40; cyc++) begin
            for (int l = 0; l < 4; l++)
               if (bus.out_valid[l] && seen[l] == 0) begin
                  seen[l] = cyc;
                  gd[l] = bus.out_data[l];
                  gr[l] = bus.out_response[l];
               end
            tick();
         end
         for (int l = 0; l < 4; l++) begin
            chk("par_latency", 64'(seen[l]), 64'(ml[l]));
            chk("par_data", 64'(gd[l]), 64'(md[l]));
            chk("par_resp", 64'(gr[l]), 64'(mr[l]));
         end
         bus.out_ready = 4'hF;
         tick();
         bus.out_ready = '0;
         for (int l = 0; l < 4; l++) begin
            exp_cnt[l] = (exp_cnt[l] + 1) & 16'hFFFF;
            chk("par_count", 64'(bus.done_count[l]), 64'(exp_cnt[l]));
         end
      end

      // Long shifts on every lane, reset lands mid-shift.
      for (int l = 0; l < 4; l++) begin
         bus.in_command[l] = CMD_SHL;
         bus.in_data1[l] = 32'(l + 1);
         bus.in_data2[l] = 32'd31;
      end
      bus.in_valid = 4'hF;
      bus.out_ready = 4'hF;
      tick();
      bus.in_valid = '0;
      for (int c = 1; c <= 45; c++) begin
         chk("mid_rst_no_valid", 64'(bus.out_valid), 64'd0);
         if (c == 9) reset = 1'b1;
         if (c == 10) reset = 1'b0;
         tick();
      end
      bus.out_ready = '0;
      for (int l = 0; l < 4; l++) begin
         exp_cnt[l] = 0;
         chk("mid_rst_count", 64'(bus.done_count[l]), 64'd0);
         chk("mid_rst_data", 64'(bus.out_data[l]), 64'd0);
         chk("mid_rst_resp", 64'(bus.out_response[l]), 64'(RESP_NONE));
         chk("mid_rst_in_ready", 64'(bus.in_ready[l]), 64'd1);
      end

      // Narrow instance: back-to-back adds and counter wrap at 16.
      busw.in_command[0] = CMD_ADD;
      busw.in_data2[0] = 8'd1;
      busw.out_ready[0] = 1'b1;
      busw.in_valid[0] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         busw.in_data1[0] = 8'(i);
         tick();
         chk("b2b_valid", 64'(busw.out_valid[0]), 64'd1);
         chk("b2b_data", 64'(busw.out_data[0]), 64'((i + 1) & 8'hFF));
         if (i == 15)
            chk("wrap_pre", 64'(busw.done_count[0]), 64'd15);
      end
      busw.in_valid[0] = 1'b0;
      tick();
      busw.out_ready[0] = 1'b0;
      chk("wrap_zero", 64'(busw.done_count[0]), 64'd0);
      chk("wrap_idle", 64'(busw.out_valid[0]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
